// File: rtl/up_axi_pkg.sv
// Shared definitions for the uP-to-AXI4-Lite master: FSM encodings and AXI response codes.
package up_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Any response other than OKAY is reported to the uP side as an error.
  function automatic logic resp_err(input logic [1:0] resp);
    return (resp != OKAY);
  endfunction

endpackage

// File: rtl/up_axi_master_rd.sv
// Read path: one uP read request becomes one AXI4-Lite AR/R transaction.
// Handshake rule: a transfer happens on a rising edge where valid & ready are both 1;
// a valid, once raised, stays high with stable payload until that edge.
module up_axi_master_rd
  import up_axi_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,
  input  logic                         up_rreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic                         up_rerr,
  output logic                         m_axi_arvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  input  logic                         m_axi_arready,
  input  logic                         m_axi_rvalid,
  input  logic [1:0]                   m_axi_rresp,
  input  logic [31:0]                  m_axi_rdata,
  output logic                         m_axi_rready,
  output rd_state_t                    rd_state_dbg
);

  rd_state_t rd_state;
  rd_state_t rd_next;

  logic ar_hs;
  logic r_hs;

  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign r_hs         = m_axi_rvalid & m_axi_rready;
  assign rd_state_dbg = rd_state;

  // State register; reset abandons any in-flight read.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) rd_state <= R_IDLE;
    else          rd_state <= rd_next;
  end

  // Next-state: requests outside R_IDLE are simply dropped.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (up_rreq) rd_next = R_ADDR;
      R_ADDR:  if (ar_hs)   rd_next = R_DATA;
      R_DATA:  if (r_hs)    rd_next = R_IDLE;
      default:              rd_next = R_IDLE;
    endcase
  end

  // AXI outputs and uP-side results, all registered.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
      up_rdata      <= 32'h0;
      up_rack       <= 1'b0;
      up_rerr       <= 1'b0;
    end else begin
      up_rack <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (up_rreq) begin
            m_axi_araddr  <= {up_raddr, 2'b00};
            m_axi_arvalid <= 1'b1;
          end
        end
        R_ADDR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            m_axi_rready <= 1'b0;
            up_rdata     <= m_axi_rdata;
            up_rerr      <= resp_err(m_axi_rresp);
            up_rack      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/up_axi_master.sv
// uP-to-AXI4-Lite master: independent write path (here) and read path (sub-module).
// Handshake rule: a transfer happens on a rising edge where valid & ready are both 1;
// a valid, once raised, stays high with stable payload until that edge.
module up_axi_master
  import up_axi_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,
  input  logic                         up_wreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_wack,
  output logic                         up_werr,
  input  logic                         up_rreq,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic                         up_rerr,
  output logic                         m_axi_awvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  input  logic                         m_axi_awready,
  output logic                         m_axi_wvalid,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_wready,
  input  logic                         m_axi_bvalid,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_bready,
  output logic                         m_axi_arvalid,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  input  logic                         m_axi_arready,
  input  logic                         m_axi_rvalid,
  input  logic [1:0]                   m_axi_rresp,
  input  logic [31:0]                  m_axi_rdata,
  output logic                         m_axi_rready,
  output wr_state_t                    wr_state_dbg,
  output rd_state_t                    rd_state_dbg
);

  wr_state_t wr_state;
  wr_state_t wr_next;

  logic aw_ok;
  logic w_ok;
  logic b_hs;

  // A channel counts as done once its valid has dropped or it handshakes this cycle,
  // so AW and W may complete in either order or together.
  assign aw_ok        = ~m_axi_awvalid | m_axi_awready;
  assign w_ok         = ~m_axi_wvalid  | m_axi_wready;
  assign b_hs         = m_axi_bvalid & m_axi_bready;
  assign wr_state_dbg = wr_state;

  // Write state register; reset abandons any in-flight write.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  // Write next-state: requests outside W_IDLE are dropped, never queued.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (up_wreq)      wr_next = W_ADDR;
      W_ADDR:  if (aw_ok & w_ok) wr_next = W_RESP;
      W_RESP:  if (b_hs)         wr_next = W_IDLE;
      default:                   wr_next = W_IDLE;
    endcase
  end

  // Write-channel outputs and uP-side write result, all registered.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= 32'h0;
      m_axi_wstrb   <= 4'hf;
      m_axi_bready  <= 1'b0;
      up_wack       <= 1'b0;
      up_werr       <= 1'b0;
    end else begin
      up_wack <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (up_wreq) begin
            m_axi_awaddr  <= {up_waddr, 2'b00};
            m_axi_wdata   <= up_wdata;
            m_axi_wstrb   <= 4'hf;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end
        end
        W_ADDR: begin
          if (m_axi_awvalid & m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid & m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_ok & w_ok)                  m_axi_bready  <= 1'b1;
        end
        W_RESP: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            up_wack      <= 1'b1;
            up_werr      <= resp_err(m_axi_bresp);
          end
        end
        default: ;
      endcase
    end
  end

  up_axi_master_rd #(
    .AXI_ADDRESS_WIDTH(AXI_ADDRESS_WIDTH)
  ) u_rd (
    .up_clk        (up_clk),
    .up_rstn       (up_rstn),
    .up_rreq       (up_rreq),
    .up_raddr      (up_raddr),
    .up_rdata      (up_rdata),
    .up_rack       (up_rack),
    .up_rerr       (up_rerr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arready (m_axi_arready),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rready  (m_axi_rready),
    .rd_state_dbg  (rd_state_dbg)
  );

endmodule

// File: tb/tb_up_axi_master.sv
// Directed bench for up_axi_master: the bench plays the AXI slave by hand, step by step.
module tb_up_axi_master;
  import up_axi_pkg::*;

  localparam int AW = 16;

  logic          up_clk;
  logic          up_rstn;
  logic          up_wreq;
  logic [AW-3:0] up_waddr;
  logic [31:0]   up_wdata;
  logic          up_wack;
  logic          up_werr;
  logic          up_rreq;
  logic [AW-3:0] up_raddr;
  logic [31:0]   up_rdata;
  logic          up_rack;
  logic          up_rerr;
  logic          m_axi_awvalid;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awready;
  logic          m_axi_wvalid;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wready;
  logic          m_axi_bvalid;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bready;
  logic          m_axi_arvalid;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arready;
  logic          m_axi_rvalid;
  logic [1:0]    m_axi_rresp;
  logic [31:0]   m_axi_rdata;
  logic          m_axi_rready;
  wr_state_t     wr_state_dbg;
  rd_state_t     rd_state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int ack_count;

  up_axi_master #(.AXI_ADDRESS_WIDTH(AW)) dut (
    .up_clk        (up_clk),
    .up_rstn       (up_rstn),
    .up_wreq       (up_wreq),
    .up_waddr      (up_waddr),
    .up_wdata      (up_wdata),
    .up_wack       (up_wack),
    .up_werr       (up_werr),
    .up_rreq       (up_rreq),
    .up_raddr      (up_raddr),
    .up_rdata      (up_rdata),
    .up_rack       (up_rack),
    .up_rerr       (up_rerr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awready (m_axi_awready),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bready  (m_axi_bready),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arready (m_axi_arready),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rready  (m_axi_rready),
    .wr_state_dbg  (wr_state_dbg),
    .rd_state_dbg  (rd_state_dbg)
  );

  // Clock: 10 ns period.
  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rresp   = 2'b00;
    m_axi_rdata   = 32'h0;
  endtask

  initial begin
    // ---------------- reset ----------------
    up_rstn  = 1'b0;
    up_wreq  = 1'b0;
    up_waddr = '0;
    up_wdata = 32'h0;
    up_rreq  = 1'b0;
    up_raddr = '0;
    slave_idle();
    #23;
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid",  m_axi_wvalid,  0);
    check("rst_bready",  m_axi_bready,  0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_rready",  m_axi_rready,  0);
    check("rst_acks",    {up_wack, up_werr, up_rack, up_rerr}, 0);
    check("rst_wstrb",   m_axi_wstrb,   32'hf);
    check("rst_awaddr",  m_axi_awaddr,  0);
    check("rst_rdata",   up_rdata,      0);
    check("rst_wstate",  wr_state_dbg,  W_IDLE);
    check("rst_rstate",  rd_state_dbg,  R_IDLE);
    up_rstn = 1'b1;
    tick();

    // ---------------- write, zero-wait slave ----------------
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    m_axi_bvalid  = 1'b1;
    m_axi_bresp   = OKAY;
    up_wreq  = 1'b1;
    up_waddr = 14'h0010;
    up_wdata = 32'hCAFE0001;
    tick();  // edge 1: request taken
    up_wreq = 1'b0;
    check("w0_awvalid", m_axi_awvalid, 1);
    check("w0_wvalid",  m_axi_wvalid,  1);
    check("w0_awaddr",  m_axi_awaddr,  32'h0040);
    check("w0_wdata",   m_axi_wdata,   32'hCAFE0001);
    check("w0_wstrb",   m_axi_wstrb,   32'hf);
    tick();  // edge 2: AW and W accepted
    check("w0_valids_drop", {m_axi_awvalid, m_axi_wvalid}, 0);
    check("w0_bready",  m_axi_bready,  1);
    check("w0_no_ack_yet", up_wack,    0);
    tick();  // edge 3: B accepted, ack
    check("w0_wack",    up_wack,       1);
    check("w0_werr",    up_werr,       0);
    check("w0_bready_drop", m_axi_bready, 0);
    slave_idle();
    tick();
    check("w0_wack_pulse", up_wack,    0);

    // ---------------- write, W before AW, error response ----------------
    m_axi_wready = 1'b1;
    up_wreq  = 1'b1;
    up_waddr = 14'h0ABC;
    up_wdata = 32'h5555AAAA;
    tick();  // edge 1
    up_wreq = 1'b0;
    check("w1_valids_up", {m_axi_awvalid, m_axi_wvalid}, 32'h3);
    tick();  // edge 2: W accepted
    m_axi_wready = 1'b0;
    check("w1_wvalid_drop", m_axi_wvalid, 0);
    check("w1_awvalid_hold", m_axi_awvalid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w1_awvalid_wait", m_axi_awvalid, 1);
      check("w1_awaddr_stable", m_axi_awaddr, 32'h2AF0);
      check("w1_bready_low", m_axi_bready, 0);
    end
    m_axi_awready = 1'b1;
    tick();  // AW accepted
    m_axi_awready = 1'b0;
    check("w1_awvalid_drop", m_axi_awvalid, 0);
    check("w1_bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = SLVERR;
    ack_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      m_axi_bvalid = 1'b0;
      if (up_wack) begin
        ack_count++;
        check("w1_werr", up_werr, 1);
      end
    end
    check("w1_ack_count", ack_count, 1);

    // ---------------- read, error response ----------------
    slave_idle();
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = 32'h12345678;
    m_axi_rresp   = SLVERR;
    up_rreq  = 1'b1;
    up_raddr = 14'h0123;
    tick();  // edge 1
    up_rreq = 1'b0;
    check("r0_arvalid", m_axi_arvalid, 1);
    check("r0_araddr",  m_axi_araddr,  32'h048C);
    tick();  // edge 2: AR accepted
    check("r0_arvalid_drop", m_axi_arvalid, 0);
    check("r0_rready", m_axi_rready, 1);
    tick();  // edge 3: R accepted
    check("r0_rack",  up_rack,  1);
    check("r0_rdata", up_rdata, 32'h12345678);
    check("r0_rerr",  up_rerr,  1);
    check("r0_rready_drop", m_axi_rready, 0);
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = 32'hDEADBEEF;
    tick();
    check("r0_rack_pulse", up_rack, 0);
    tick();
    check("r0_rdata_hold", up_rdata, 32'h12345678);

    // ---------------- concurrent write and read ----------------
    slave_idle();
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = 32'hA5A50000;
    m_axi_rresp   = OKAY;
    up_wreq  = 1'b1;
    up_waddr = 14'h0001;
    up_wdata = 32'h00000011;
    up_rreq  = 1'b1;
    up_raddr = 14'h0002;
    tick();  // edge 1: both issued together
    up_wreq = 1'b0;
    up_rreq = 1'b0;
    check("c_all_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'h7);
    check("c_awaddr", m_axi_awaddr, 32'h0004);
    check("c_araddr", m_axi_araddr, 32'h0008);
    tick();  // edge 2: write in W_RESP, read in R_DATA
    check("c_bready", m_axi_bready, 1);
    check("c_rready", m_axi_rready, 1);
    up_wreq  = 1'b1;  // must be ignored: write is busy
    up_waddr = 14'h0333;
    tick();  // edge 3: read completes
    up_wreq = 1'b0;
    m_axi_rvalid = 1'b0;
    check("c_rack",  up_rack,  1);
    check("c_rdata", up_rdata, 32'hA5A50000);
    check("c_rerr",  up_rerr,  0);
    check("c_ignored_awvalid", m_axi_awvalid, 0);
    check("c_wack_pending", up_wack, 0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = OKAY;
    ack_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      m_axi_bvalid = 1'b0;
      if (up_wack) begin
        ack_count++;
        check("c_werr", up_werr, 0);
      end
      check("c_no_queued_aw", m_axi_awvalid, 0);
      check("c_no_second_rack", up_rack, 0);
    end
    check("c_wack_count", ack_count, 1);
    check("c_awaddr_unchanged", m_axi_awaddr, 32'h0004);

    // ---------------- reset during W_RESP ----------------
    slave_idle();
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    up_wreq  = 1'b1;
    up_waddr = 14'h0042;
    up_wdata = 32'h77777777;
    up_rreq  = 1'b1;
    up_raddr = 14'h0044;
    tick();  // edge 1
    up_wreq = 1'b0;
    up_rreq = 1'b0;
    tick();  // edge 2: write now in W_RESP, read waiting in R_ADDR
    check("x_bready_pre", m_axi_bready, 1);
    check("x_wstate_pre", wr_state_dbg, W_RESP);
    check("x_arvalid_pre", m_axi_arvalid, 1);
    #2;
    up_rstn = 1'b0;
    #1;  // no clock edge in between: reset acts asynchronously
    check("x_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
    check("x_readies", {m_axi_bready, m_axi_rready}, 0);
    check("x_rdata_clr", up_rdata, 0);
    check("x_awaddr_clr", m_axi_awaddr, 0);
    check("x_wstate", wr_state_dbg, W_IDLE);
    m_axi_bvalid  = 1'b1;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b1;
    tick();
    tick();
    up_rstn = 1'b1;
    ack_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (up_wack || up_rack) ack_count++;
      check("x_bready_idle", m_axi_bready, 0);
    end
    check("x_no_ack_after_reset", ack_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net: the directed sequence is short; stop if it somehow stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no end of sequence, required finish before 100000 ns");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/up_axi_master.md
UP_AXI_MASTER -- requirements
Module: up_axi_master

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_WIDTH, default 16; it sets the byte-address width on the AXI side.
REQ-002 SHALL have port up_clk, input, 1 bit; the single clock.
REQ-003 SHALL have port up_rstn, input, 1 bit; reset, asynchronous, active-low.
REQ-004 SHALL have up_wreq, input, 1; write request pulse.
REQ-005 SHALL have up_waddr, input, AXI_ADDRESS_WIDTH-2; word address.
REQ-006 SHALL have up_wdata, input, 32; write data.
REQ-007 SHALL have up_wack, output, 1; write-complete pulse.
REQ-008 SHALL have up_werr, output, 1; write error, valid with up_wack.
REQ-009 SHALL have up_rreq, input, 1; read request pulse.
REQ-010 SHALL have up_raddr, input, AXI_ADDRESS_WIDTH-2; word address.
REQ-011 SHALL have up_rdata, output, 32; read data.
REQ-012 SHALL have up_rack, output, 1; read-complete pulse.
REQ-013 SHALL have up_rerr, output, 1; read error, valid with up_rack.
REQ-014 SHALL have AXI4-Lite master ports m_axi_awvalid/awaddr[AW-1:0]/awready, wvalid/wdata[31:0]/wstrb[3:0]/wready, bvalid/bresp[1:0]/bready, arvalid/araddr[AW-1:0]/arready, rvalid/rresp[1:0]/rdata[31:0]/rready, with the standard directions for a master.

Function
REQ-015 Write FSM states SHALL be W_IDLE, W_ADDR and W_RESP.
REQ-016 Write, W_IDLE: on up_wreq=1, SHALL register awaddr={up_waddr,2'b00} and wdata=up_wdata, drive wstrb=4'hf, raise awvalid and wvalid on the next edge, and go to W_ADDR.
REQ-017 Write, W_ADDR: awvalid SHALL drop the cycle after the awvalid&awready handshake, and wvalid SHALL drop the cycle after the wvalid&wready handshake. The two handshakes are independent and may occur in either order or in the same cycle.
REQ-018 Write, W_ADDR: once both handshakes have completed, the FSM SHALL go to W_RESP with bready=1.
REQ-019 Write, W_RESP: on bvalid&bready, the block SHALL drop bready, pulse up_wack for exactly one cycle on the next edge with up_werr=(bresp!=2'b00), and return to W_IDLE.
REQ-020 Write: up_wreq received outside W_IDLE SHALL be ignored, with no queueing.
REQ-021 Write: awaddr, wdata and wstrb SHALL remain stable while their valid is high.
REQ-022 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA.
REQ-023 Read, R_IDLE: on up_rreq=1, SHALL register araddr={up_raddr,2'b00}, raise arvalid on the next edge, and go to R_ADDR.
REQ-024 Read, R_ADDR: on arvalid&arready, SHALL drop arvalid, raise rready, and go to R_DATA.
REQ-025 Read, R_DATA: on rvalid&rready, SHALL capture rdata into up_rdata and set up_rerr=(rresp!=2'b00).
REQ-026 Read, R_DATA: after the rvalid&rready handshake, the block SHALL pulse up_rack for one cycle on the next edge, drop rready, and return to R_IDLE.
REQ-027 Read: up_rdata SHALL hold its captured value until the next read completes.
REQ-028 Read: up_rreq received outside R_IDLE SHALL be ignored.
REQ-029 The read and write FSMs SHALL be fully independent; simultaneous up_wreq and up_rreq SHALL both be issued in the same cycle.
REQ-030 Minimum latency, with all AXI ready/valid signals responding immediately, SHALL be 3 cycles from the request edge to the ack.
REQ-031 The block SHALL never deassert a valid before its handshake, and SHALL never assert bready/rready outside W_RESP/R_DATA respectively.

Reset
REQ-032 On up_rstn=0, asynchronously, all AXI valid/ready outputs, up_wack, up_rack, up_werr and up_rerr SHALL be 0, and both FSMs SHALL be in their IDLE state.
REQ-033 On up_rstn=0, asynchronously, awaddr, araddr, wdata and up_rdata SHALL be 0, and wstrb SHALL be 4'hf.
REQ-034 A reset asserted mid-transaction SHALL abandon the transaction, with no ack generated after reset release.

Structure
REQ-035 A shared package up_axi_pkg SHALL hold the FSM state encodings and the AXI response constants OKAY=2'b00, SLVERR=2'b10 and DECERR=2'b11.
REQ-036 The read path SHALL be one sub-module, up_axi_master_rd. The write path SHALL remain in the top level.

Verification
REQ-037 Write, zero-wait slave: up_wreq with up_waddr=0x0010 and up_wdata=0xCAFE0001 -> awaddr=0x0040 and wdata=0xCAFE0001, wstrb=0xf, up_wack at the 3rd edge, up_werr=0.
REQ-038 Write with W before AW: wready=1 at cycle 1 and awready held low 5 cycles -> wvalid drops at cycle 2, awvalid held stable until accepted, exactly one up_wack.
REQ-039 Read returning an error: rdata=0x12345678 with rresp=2'b10 -> up_rack one cycle, up_rdata=0x12345678, up_rerr=1, up_rdata held afterwards.
REQ-040 Concurrent write and read: up_wreq and up_rreq in the same cycle -> both channels issued in the same cycle, each ack exactly once; a second up_wreq while in W_RESP is ignored.
REQ-041 Reset during W_RESP: all valids/readies are 0 immediately, and no up_wack follows reset release.
